// File: rtl/alu_pkg.sv
// Shared definitions for the ALU display/result selector scan logic:
// one-hot select codes, scan states and capture field widths.
package alu_pkg;

  localparam int SEL_W = 4;
  localparam int A_W   = 4;
  localparam int B_W   = 4;
  localparam int Y_W   = 8;
  localparam int OP_W  = 3;

  localparam logic [SEL_W-1:0] SEL_NONE = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_A    = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_B    = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_Y    = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_OP   = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A,
    ST_B,
    ST_Y,
    ST_OP
  } state_t;

  // One-hot select code presented to the selector while in a given state
  function automatic logic [SEL_W-1:0] sel_of(state_t s);
    case (s)
      ST_A:    sel_of = SEL_A;
      ST_B:    sel_of = SEL_B;
      ST_Y:    sel_of = SEL_Y;
      ST_OP:   sel_of = SEL_OP;
      default: sel_of = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Slot dwell counter: counts DWELL unheld cycles per slot and flags the
// last one. Held at zero while not running; frozen while i_hold is high.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_hold,
  output logic o_last
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_count;

  // Count unheld cycles within a slot, restarting at zero after the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_run) begin
      r_count <= '0;
    end else if (!i_hold) begin
      if (r_count == LAST) r_count <= '0;
      else                 r_count <= r_count + 1'b1;
    end
  end

  // Last-cycle strobe only fires on an unheld cycle, so a held slot end defers it
  assign o_last = i_run && !i_hold && (r_count == LAST);

endmodule

// File: rtl/select_scan.sv
// Scans the shared ALU selector through A, B, Y and OP with a one-hot
// select, captures the selector output per slot and reports frame
// completion together with a change flag against the previous frame.
module select_scan
  import alu_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             hold,
  input  logic [7:0]       sO,
  output logic [SEL_W-1:0] select,
  output logic [A_W-1:0]   a_cap,
  output logic [B_W-1:0]   b_cap,
  output logic [Y_W-1:0]   y_cap,
  output logic [OP_W-1:0]  op_cap,
  output logic             frame_done,
  output logic             changed,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next_state;
  logic [SEL_W-1:0] r_select;
  logic [A_W-1:0]   r_a_cap;
  logic [B_W-1:0]   r_b_cap;
  logic [Y_W-1:0]   r_y_cap;
  logic [OP_W-1:0]  r_op_cap;
  logic             r_frame_done;
  logic             r_changed;
  logic             r_diff;

  logic w_run;
  logic w_last;
  logic w_cap_a;
  logic w_cap_b;
  logic w_cap_y;
  logic w_cap_op;
  logic w_diff_a;
  logic w_diff_b;
  logic w_diff_y;
  logic w_diff_op;

  assign w_run = (r_state != ST_IDLE);

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .i_run  (w_run),
    .i_hold (hold),
    .o_last (w_last)
  );

  assign w_cap_a  = w_last && (r_state == ST_A);
  assign w_cap_b  = w_last && (r_state == ST_B);
  assign w_cap_y  = w_last && (r_state == ST_Y);
  assign w_cap_op = w_last && (r_state == ST_OP);

  assign w_diff_a  = (sO[A_W-1:0]  != r_a_cap);
  assign w_diff_b  = (sO[B_W-1:0]  != r_b_cap);
  assign w_diff_y  = (sO[Y_W-1:0]  != r_y_cap);
  assign w_diff_op = (sO[OP_W-1:0] != r_op_cap);

  // State register; select is registered alongside so it tracks the state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_select <= SEL_NONE;
    end else begin
      r_state  <= w_next_state;
      r_select <= sel_of(w_next_state);
    end
  end

  // Next state: advance on each slot's last unheld cycle; enable only matters at frame boundaries
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (enable && !hold) w_next_state = ST_A;
      ST_A:    if (w_last)          w_next_state = ST_B;
      ST_B:    if (w_last)          w_next_state = ST_Y;
      ST_Y:    if (w_last)          w_next_state = ST_OP;
      ST_OP:   if (w_last)          w_next_state = enable ? ST_A : ST_IDLE;
      default:                      w_next_state = ST_IDLE;
    endcase
  end

  // Outputs: registered select/captures/flags, busy decoded from the state
  always_comb begin
    select     = r_select;
    a_cap      = r_a_cap;
    b_cap      = r_b_cap;
    y_cap      = r_y_cap;
    op_cap     = r_op_cap;
    frame_done = r_frame_done;
    changed    = r_changed;
    busy       = (r_state != ST_IDLE);
  end

  // Per-slot capture of the selector output on the slot's last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_cap  <= '0;
      r_b_cap  <= '0;
      r_y_cap  <= '0;
      r_op_cap <= '0;
    end else begin
      if (w_cap_a)  r_a_cap  <= sO[A_W-1:0];
      if (w_cap_b)  r_b_cap  <= sO[B_W-1:0];
      if (w_cap_y)  r_y_cap  <= sO[Y_W-1:0];
      if (w_cap_op) r_op_cap <= sO[OP_W-1:0];
    end
  end

  // Accumulate per-slot differences over the frame; the A capture starts a fresh frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff <= 1'b0;
    end else if (w_cap_a) begin
      r_diff <= w_diff_a;
    end else if (w_cap_b) begin
      r_diff <= r_diff | w_diff_b;
    end else if (w_cap_y) begin
      r_diff <= r_diff | w_diff_y;
    end
  end

  // Frame-complete pulse and change flag, both for the single cycle after the OP capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_changed    <= 1'b0;
    end else begin
      r_frame_done <= w_cap_op;
      r_changed    <= w_cap_op && (r_diff || w_diff_op);
    end
  end

endmodule

// File: tb/tb_select_scan.sv
// Bench for select_scan: a DWELL=4 instance driven through a selector model
// with a frame scoreboard, plus a DWELL=1 instance for the single-cycle case.
module tb_select_scan;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] y;
    logic [2:0] op;
    logic       chg;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       hold;
  logic [7:0] sO;
  logic [3:0] select;
  logic [3:0] a_cap;
  logic [3:0] b_cap;
  logic [7:0] y_cap;
  logic [2:0] op_cap;
  logic       frame_done;
  logic       changed;
  logic       busy;

  logic       enable2;
  logic       hold2;
  logic [7:0] sO2;
  logic [3:0] select2;
  logic [3:0] a_cap2;
  logic [3:0] b_cap2;
  logic [7:0] y_cap2;
  logic [2:0] op_cap2;
  logic       frame_done2;
  logic       changed2;
  logic       busy2;

  logic [7:0] sv_a;
  logic [7:0] sv_b;
  logic [7:0] sv_y;
  logic [7:0] sv_op;

  int   errors;
  int   checks;
  exp_t sb[$];
  exp_t mon_e;

  select_scan #(.DWELL(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .hold(hold), .sO(sO),
    .select(select), .a_cap(a_cap), .b_cap(b_cap), .y_cap(y_cap),
    .op_cap(op_cap), .frame_done(frame_done), .changed(changed), .busy(busy)
  );

  select_scan #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable2), .hold(hold2), .sO(sO2),
    .select(select2), .a_cap(a_cap2), .b_cap(b_cap2), .y_cap(y_cap2),
    .op_cap(op_cap2), .frame_done(frame_done2), .changed(changed2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selector model: output bus follows the one-hot select combinationally
  always_comb begin
    case (select)
      4'b0001: sO = sv_a;
      4'b0010: sO = sv_b;
      4'b0100: sO = sv_y;
      4'b1000: sO = sv_op;
      default: sO = 8'h00;
    endcase
  end

  always_comb begin
    case (select2)
      4'b0001: sO2 = 8'h01;
      4'b0010: sO2 = 8'h02;
      4'b0100: sO2 = 8'h03;
      4'b1000: sO2 = 8'h04;
      default: sO2 = 8'h00;
    endcase
  end

  // Scoreboard monitor for the DWELL=4 instance
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_frame: frame_done=1 with no frame expected");
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if ({a_cap, b_cap, y_cap, op_cap, changed} !== mon_e) begin
            errors++;
            $display("FAIL sb_frame: got a=%h b=%h y=%h op=%h chg=%b, required a=%h b=%h y=%h op=%h chg=%b",
                     a_cap, b_cap, y_cap, op_cap, changed,
                     mon_e.a, mon_e.b, mon_e.y, mon_e.op, mon_e.chg);
          end
        end
      end else begin
        checks++;
        if (changed !== 1'b0) begin
          errors++;
          $display("FAIL changed_without_frame: got changed=%b, required 0", changed);
        end
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 300);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; hold = 1'b0; enable2 = 1'b0; hold2 = 1'b0;
    sv_a = 8'h5A; sv_b = 8'h5A; sv_y = 8'h5A; sv_op = 8'h5A;
    @(negedge clk);
    checks++;
    if ({select, a_cap, b_cap, y_cap, op_cap} !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%b a=%h b=%h y=%h op=%h, required all 0",
               select, a_cap, b_cap, y_cap, op_cap);
    end
    checks++;
    if ({frame_done, changed, busy, select2, busy2} !== 8'h0) begin
      errors++;
      $display("FAIL reset_flags: got fd=%b chg=%b busy=%b sel2=%b busy2=%b, required 0",
               frame_done, changed, busy, select2, busy2);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (select !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_enable: got sel=%b busy=%b, required 0000/0", select, busy);
    end
  endtask

  task automatic test_first_frame();
    logic [3:0] exp_sel;
    sb.push_back('{a: 4'hA, b: 4'hA, y: 8'h5A, op: 3'h2, chg: 1'b1});
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_sel = 4'(1 << ((k - 1) / 4));
      checks++;
      if (select !== exp_sel || busy !== 1'b1) begin
        errors++;
        $display("FAIL frame1_select k=%0d: got sel=%b busy=%b, required sel=%b busy=1",
                 k, select, busy, exp_sel);
      end
      if (k == 5) begin
        checks++;
        if (a_cap !== 4'hA) begin
          errors++;
          $display("FAIL frame1_a_early: got a=%h, required a", a_cap);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame1_done_cycle17: got frame_done=%b, required 1", frame_done);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    sb.push_back('{a: 4'hA, b: 4'hA, y: 8'h5A, op: 3'h2, chg: 1'b0});
    wait_done(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL repeat_frame_len: got %0d cycles, required 16", n);
    end
    sv_y = 8'h3C;
    sb.push_back('{a: 4'hA, b: 4'hA, y: 8'h3C, op: 3'h2, chg: 1'b1});
    wait_done(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL y_change_frame_len: got %0d cycles, required 16", n);
    end
  endtask

  task automatic test_hold();
    int n;
    sv_b = 8'h07;
    sb.push_back('{a: 4'hA, b: 4'h7, y: 8'h3C, op: 3'h2, chg: 1'b1});
    repeat (6) @(negedge clk);
    checks++;
    if (select !== 4'b0010) begin
      errors++;
      $display("FAIL hold_pre_select: got sel=%b, required 0010", select);
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (select !== 4'b0010 || b_cap !== 4'hA) begin
        errors++;
        $display("FAIL hold_frozen i=%0d: got sel=%b b=%h, required 0010/a", i, select, b_cap);
      end
    end
    hold = 1'b0;
    wait_done(n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL hold_frame_len: got %0d cycles after release, required 10", n);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    int pulses;
    sb.push_back('{a: 4'hA, b: 4'h7, y: 8'h3C, op: 3'h2, chg: 1'b0});
    repeat (9) @(negedge clk);
    checks++;
    if (select !== 4'b0100) begin
      errors++;
      $display("FAIL drop_in_y: got sel=%b, required 0100", select);
    end
    enable = 1'b0;
    wait_done(n);
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL drop_frame_completes: got %0d cycles, required 7", n);
    end
    checks++;
    if (select !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: got sel=%b busy=%b, required 0000/0", select, busy);
    end
    sv_a = 8'h0F;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1 || select !== 4'b0000) pulses++;
    end
    checks++;
    if (pulses != 0 || a_cap !== 4'hA || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_stays_idle: got activity=%0d a=%h busy=%b, required 0/a/0",
               pulses, a_cap, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    sv_a = 8'h5A;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (select !== 4'b0100) begin
      errors++;
      $display("FAIL rst_mid_in_y: got sel=%b, required 0100", select);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({select, a_cap, b_cap, y_cap, op_cap, busy} !== 24'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got sel=%b a=%h b=%h y=%h op=%h busy=%b, required all 0",
               select, a_cap, b_cap, y_cap, op_cap, busy);
    end
    sb.push_back('{a: 4'hA, b: 4'h7, y: 8'h3C, op: 3'h2, chg: 1'b1});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (select !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart: got sel=%b busy=%b, required 0001/1", select, busy);
    end
    enable = 1'b0;
    wait_done(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL rst_restart_len: got %0d cycles, required 16", n);
    end
    @(negedge clk);
    checks++;
    if (select !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart_idle: got sel=%b busy=%b, required 0000/0", select, busy);
    end
  endtask

  task automatic test_dwell1();
    logic [3:0] exp_sel;
    enable2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_sel = 4'(1 << (k - 1));
      checks++;
      if (select2 !== exp_sel || frame_done2 !== 1'b0) begin
        errors++;
        $display("FAIL d1_select k=%0d: got sel=%b fd=%b, required sel=%b fd=0",
                 k, select2, frame_done2, exp_sel);
      end
    end
    @(negedge clk);
    enable2 = 1'b0;
    checks++;
    if ({frame_done2, changed2, a_cap2, b_cap2, y_cap2, op_cap2} !== {1'b1, 1'b1, 4'h1, 4'h2, 8'h03, 3'h4}) begin
      errors++;
      $display("FAIL d1_frame: got fd=%b chg=%b a=%h b=%h y=%h op=%h, required 1/1/1/2/03/4",
               frame_done2, changed2, a_cap2, b_cap2, y_cap2, op_cap2);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (frame_done2 !== 1'b1 || changed2 !== 1'b0) begin
      errors++;
      $display("FAIL d1_b2b_frame: got fd=%b chg=%b, required 1/0", frame_done2, changed2);
    end
    @(negedge clk);
    checks++;
    if (select2 !== 4'b0000 || busy2 !== 1'b0 || frame_done2 !== 1'b0) begin
      errors++;
      $display("FAIL d1_idle: got sel=%b busy=%b fd=%b, required 0000/0/0", select2, busy2, frame_done2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_hold();
    test_enable_drop();
    test_reset_mid();
    test_dwell1();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: got %0d pending frames, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/select_scan.md
Name: select_scan

Overview:
- Drives the one-hot 4-bit select bus that the ALU's shared 8-bit display/result selector consumes.
- Samples the selector's output bus sO once per slot and demultiplexes it into per-source capture registers: A, B, Y and the opcode.
- Produces a frame-complete pulse, plus a change flag, for downstream display/compare logic.

Parameters:
- DWELL, 4, cycles each select slot is held (legal 1..256); sample taken on the last cycle of the slot.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  run scanning; sampled at frame boundaries and in IDLE.
- hold  input  1  freezes dwell counter, select and captures while high.
- sO  input  8  selector output bus (combinational from selector).
- select  output  4  one-hot source select to selector; 0000 when idle.
- a_cap  output  4  sO[3:0] captured in slot A.
- b_cap  output  4  sO[3:0] captured in slot B.
- y_cap  output  8  sO[7:0] captured in slot Y.
- op_cap  output  3  sO[2:0] captured in slot OP.
- frame_done  output  1  one-cycle pulse after the OP capture.
- changed  output  1  valid with frame_done: any capture differs from the previous frame's value.
- busy  output  1  high whenever not IDLE.

Behaviour:
- Reset (async, immediate): state IDLE, select=0000, count=0, all *_cap=0, frame_done=0, changed=0, busy=0.
- States: IDLE, S_A, S_B, S_Y, S_OP.
  - select encodings: S_A→0001, S_B→0010, S_Y→0100, S_OP→1000.
  - select is registered and equals the state encoding.
- IDLE:
  - enable=1 at edge t → state S_A from cycle t+1, count=0, busy=1.
  - enable=0 → remain IDLE.
- In any S_* state:
  - hold=1: count, state and captures frozen; frame_done forced 0.
  - hold=0 and count<DWELL-1: count+1.
  - hold=0 and count==DWELL-1 (last cycle): capture sO into that slot's register at that edge, count=0, advance A→B→Y→OP.
- Slot length is exactly DWELL unheld cycles. First capture is DWELL cycles after S_A entry; frame length is 4*DWELL unheld cycles.
- Capture mapping:
  - S_A: a_cap←sO[3:0].
  - S_B: b_cap←sO[3:0].
  - S_Y: y_cap←sO[7:0].
  - S_OP: op_cap←sO[2:0].
  - Unused sO bits ignored.
- End of S_OP:
  - frame_done=1 for the single cycle after the capture edge.
  - Next state is S_A if enable=1 at that edge (back-to-back frames, no gap); otherwise IDLE with select=0000.
- Enable dropped mid-frame: the current frame completes, including frame_done; the block then idles. No partial frames.
- changed:
  - Registered alongside frame_done.
  - =1 if any of the four new captures differs from the value held before this frame's capture.
  - The first frame after reset compares against the reset zeros.
  - changed=0 whenever frame_done=0.
- DWELL=1: one capture per cycle; count is held at 0.
- Counter width: max(1, clog2(DWELL)) bits; count never exceeds DWELL-1, so there is no wrap condition.
- Simultaneous events:
  - hold=1 on the last cycle of a slot defers the capture until hold drops.
  - enable is ignored while hold=1.

Decomposition:
- Shared package alu_pkg holds:
  - select one-hot constants SEL_A/SEL_B/SEL_Y/SEL_OP;
  - the state enum;
  - capture widths (4, 4, 8, 3).
- One sub-module, dwell_timer, is natural: counter with hold, parameter DWELL, output last-cycle strobe.
- Everything else (FSM, captures, compare) stays in select_scan.

Test Plan:
- Reset then enable=1, DWELL=4, sO=0x5A throughout:
  - select goes 0001,0010,0100,1000, each for 4 cycles;
  - a_cap=A, b_cap=A, y_cap=5A, op_cap=2;
  - frame_done at cycle 17 after enable;
  - changed=1.
- Repeat the frame with the same sO → frame_done=1, changed=0. Then change only the slot-Y sO to 0x3C → y_cap=3C, changed=1.
- hold=1 for 3 cycles during S_B cycle 3 → select stays 0010, b_cap unchanged; capture occurs on the first unheld last cycle; frame is 3 cycles longer.
- enable=0 during S_Y → S_OP still runs, frame_done pulses once, then select=0000, busy=0, with no further captures.
- Assert rst mid-S_Y → same cycle: select=0000, all caps 0, busy=0; after release with enable=1, restart at S_A.
- DWELL=1, sO stepping 1,2,3,4 per cycle → a_cap=1, b_cap=2, y_cap=3, op_cap=4; frame_done on the 5th cycle.
